// File: rtl/cache_nway_wt.sv
// cache_nway_wt: clocked N-way set-associative write-through cache with true LRU
module cache_nway_wt #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int BLOCK_BYTES = 16,
    parameter int SETS        = 2,
    parameter int WAYS        = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req_valid,
    output logic                          cpu_req_ready,
    input  logic                          cpu_req_we,
    input  logic [ADDR_W-1:0]             cpu_req_addr,
    input  logic [DATA_W-1:0]             cpu_req_wdata,
    output logic                          cpu_resp_valid,
    output logic                          cpu_resp_hit,
    output logic [DATA_W-1:0]             cpu_resp_rdata,
    output logic                          mem_req_valid,
    output logic                          mem_req_we,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [BLOCK_BYTES*DATA_W-1:0] mem_req_wdata,
    input  logic                          mem_ack,
    input  logic [BLOCK_BYTES*DATA_W-1:0] mem_rdata
);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int IDX_W  = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int AGE_W  = $clog2(WAYS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = BLOCK_BYTES * DATA_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WTHRU, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d, hit_q, hit_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [AGE_W-1:0]    way_q, way_d;
    logic                resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_req_valid_q, mem_req_valid_d, mem_req_we_q, mem_req_we_d;
    logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [LINE_W-1:0]   mem_req_wdata_q, mem_req_wdata_d;

    logic [LINE_W-1:0]   data_q [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q  [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS], valid_d [SETS];
    logic [AGE_W-1:0]    age_q [SETS][WAYS], age_d [SETS][WAYS];

    logic [TAG_W-1:0]    a_tag;
    logic [IDX_W-1:0]    idx;
    logic [OFF_W-1:0]    off;
    logic [ADDR_W-1:0]   blk_addr;
    logic                hit, found;
    logic [AGE_W-1:0]    hit_way, victim, wr_way, lru_way;
    logic                wr_en, lru_en;
    logic [LINE_W-1:0]   hit_line, wr_line;

    assign a_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign idx      = addr_q[OFF_W +: IDX_W];
    assign off      = addr_q[OFF_W-1:0];
    assign blk_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign hit_line = data_q[idx][hit_way];

    assign cpu_req_ready  = (state_q == IDLE);
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign cpu_resp_rdata = rdata_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_we     = mem_req_we_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign mem_req_wdata  = mem_req_wdata_q;

    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] l, input logic [OFF_W-1:0] o,
                                                input logic [DATA_W-1:0] b);
        logic [LINE_W-1:0] r;
        r = l;
        r[o*DATA_W +: DATA_W] = b;
        return r;
    endfunction

    // Tag match across the addressed set and victim choice (first invalid way, else the oldest)
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == a_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!found && !valid_q[idx][w]) begin
                found  = 1'b1;
                victim = AGE_W'(w);
            end
        end
        if (!found)
            for (int w = 0; w < WAYS; w++)
                if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end

    // Controller next state, line writes, memory requests and LRU ageing
    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        way_d           = way_q;
        hit_d           = hit_q;
        resp_valid_d    = 1'b0;
        resp_hit_d      = resp_hit_q;
        rdata_d         = rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        valid_d         = valid_q;
        age_d           = age_q;
        wr_en           = 1'b0;
        wr_way          = way_q;
        wr_line         = mem_rdata;
        lru_en          = 1'b0;
        lru_way         = way_q;
        case (state_q)
            IDLE: if (cpu_req_valid) begin
                we_d    = cpu_req_we;
                addr_d  = cpu_req_addr;
                wdata_d = cpu_req_wdata;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                mem_req_addr_d = blk_addr;
                if (hit) begin
                    lru_en  = 1'b1;
                    lru_way = hit_way;
                    way_d   = hit_way;
                    hit_d   = 1'b1;
                    if (we_q) begin
                        wr_en           = 1'b1;
                        wr_way          = hit_way;
                        wr_line         = merge(hit_line, off, wdata_q);
                        mem_req_valid_d = 1'b1;
                        mem_req_we_d    = 1'b1;
                        mem_req_wdata_d = merge(hit_line, off, wdata_q);
                        state_d         = WTHRU;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_hit_d   = 1'b1;
                        rdata_d      = hit_line[off*DATA_W +: DATA_W];
                        state_d      = RESP;
                    end
                end else begin
                    way_d           = victim;
                    hit_d           = 1'b0;
                    mem_req_valid_d = 1'b1;
                    mem_req_we_d    = 1'b0;
                    state_d         = FILL;
                end
            end
            FILL: if (mem_ack) begin
                wr_en   = 1'b1;
                lru_en  = 1'b1;
                wr_line = we_q ? merge(mem_rdata, off, wdata_q) : mem_rdata;
                if (we_q) begin
                    mem_req_we_d    = 1'b1;
                    mem_req_wdata_d = merge(mem_rdata, off, wdata_q);
                    state_d         = WTHRU;
                end else begin
                    mem_req_valid_d = 1'b0;
                    resp_valid_d    = 1'b1;
                    resp_hit_d      = 1'b0;
                    rdata_d         = mem_rdata[off*DATA_W +: DATA_W];
                    state_d         = RESP;
                end
            end
            WTHRU: if (mem_ack) begin
                mem_req_valid_d = 1'b0;
                resp_valid_d    = 1'b1;
                resp_hit_d      = hit_q;
                rdata_d         = wdata_q;
                state_d         = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wr_en) valid_d[idx][wr_way] = 1'b1;
        if (lru_en)
            for (int w = 0; w < WAYS; w++)
                age_d[idx][w] = (AGE_W'(w) == lru_way) ? '0 :
                                (age_q[idx][w] < age_q[idx][lru_way]) ? age_q[idx][w] + AGE_W'(1) :
                                age_q[idx][w];
    end

    // Control, response and request registers; valid bits cleared and ages seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            way_q           <= '0;
            hit_q           <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            rdata_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            way_q           <= way_d;
            hit_q           <= hit_d;
            resp_valid_q    <= resp_valid_d;
            resp_hit_q      <= resp_hit_d;
            rdata_q         <= rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            valid_q         <= valid_d;
            age_q           <= age_d;
        end
    end

    // Line data and tags carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[idx][wr_way] <= wr_line;
            tag_q[idx][wr_way]  <= a_tag;
        end
    end
endmodule
